// File: rtl/coreaxitoahbl_ram_strb_sync.sv
// Byte-strobed RAM with a two-stage write path (pending register, then commit),
// per-entry valid bits, optional forwarding of the pending write to the read
// port, and either a combinational or a registered read port.
module coreaxitoahbl_ram_strb_sync #(
  parameter int AXI_DWIDTH    = 64,
  parameter int AXI_STRBWIDTH = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int RD_MODE       = 0,
  parameter int FWD_EN        = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     wrEn,
  input  logic [ADDR_WIDTH-1:0]    wrAddr,
  input  logic [AXI_DWIDTH-1:0]    wrData,
  input  logic [AXI_STRBWIDTH-1:0] wrStrb,
  input  logic                     clrValid,
  input  logic                     rdEn,
  input  logic [ADDR_WIDTH-1:0]    rdAddr,
  output logic [AXI_DWIDTH-1:0]    rdData,
  output logic                     rdValid
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [AXI_DWIDTH-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]         validBits;

  logic                     pendValid;
  logic [ADDR_WIDTH-1:0]    pendAddr;
  logic [AXI_DWIDTH-1:0]    pendData;
  logic [AXI_STRBWIDTH-1:0] pendStrb;

  logic                     wrInRange;
  logic                     rdInRange;
  logic [IDXW-1:0]          pendIdx;
  logic [IDXW-1:0]          rdIdx;

  logic [AXI_DWIDTH-1:0]    rdWordC;
  logic                     rdValidC;

  assign wrInRange = ({1'b0, wrAddr} < DEPTH_LIM);
  assign rdInRange = ({1'b0, rdAddr} < DEPTH_LIM);
  assign pendIdx   = pendAddr[IDXW-1:0];
  assign rdIdx     = rdAddr[IDXW-1:0];

  // Pending stage and valid bits; out-of-range writes never become pending,
  // so they can neither touch memory nor set a valid bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pendValid <= 1'b0;
      pendAddr  <= '0;
      pendData  <= '0;
      pendStrb  <= '0;
      validBits <= '0;
    end else begin
      pendValid <= wrEn && wrInRange;
      if (wrEn) begin
        pendAddr <= wrAddr;
        pendData <= wrData;
        pendStrb <= wrStrb;
      end
      if (clrValid) begin
        validBits <= '0;
      end else if (pendValid) begin
        validBits[pendIdx] <= 1'b1;
      end
    end
  end

  // Commit of the pending write into the array; the array itself is never reset,
  // but a reset edge suppresses the commit of an outstanding write.
  always_ff @(posedge CLK) begin
    if (!RESET && pendValid) begin
      for (int unsigned b = 0; b < AXI_STRBWIDTH; b++) begin
        if (pendStrb[b]) begin
          mem[pendIdx][8*b +: 8] <= pendData[8*b +: 8];
        end
      end
    end
  end

  // Read lookup: memory word plus byte-wise overlay of a matching pending write.
  always_comb begin
    rdWordC  = '0;
    rdValidC = 1'b0;
    if (rdInRange) begin
      rdWordC  = mem[rdIdx];
      rdValidC = validBits[rdIdx];
      if ((FWD_EN != 0) && pendValid && (pendAddr == rdAddr)) begin
        for (int unsigned b = 0; b < AXI_STRBWIDTH; b++) begin
          if (pendStrb[b]) begin
            rdWordC[8*b +: 8] = pendData[8*b +: 8];
          end
        end
        rdValidC = 1'b1;
      end
    end
  end

  generate
    if (RD_MODE == 0) begin : gAsyncRead
      logic unusedRdEn;
      assign unusedRdEn = rdEn;
      assign rdData     = rdWordC;
      assign rdValid    = rdValidC;
    end else begin : gRegRead
      logic [AXI_DWIDTH-1:0] rdDataQ;
      logic                  rdValidQ;

      // Registered read: capture the lookup on rdEn, hold otherwise.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          rdDataQ  <= '0;
          rdValidQ <= 1'b0;
        end else if (rdEn) begin
          rdDataQ  <= rdWordC;
          rdValidQ <= rdValidC;
        end
      end

      assign rdData  = rdDataQ;
      assign rdValid = rdValidQ;
    end
  endgenerate

endmodule

// File: tb/tb_coreaxitoahbl_ram_strb_sync.sv
// Bench for coreaxitoahbl_ram_strb_sync: three instances sharing one input
// stream (async+forwarding, async+no forwarding with DEPTH=12, registered
// read+forwarding), each compared against its own behavioural model.
module tb_coreaxitoahbl_ram_strb_sync;

  logic        CLK;
  logic        RESET;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrStrb;
  logic        clrValid;
  logic        rdEn;
  logic [3:0]  rdAddr;

  logic [31:0] rdD0, rdD1, rdD2;
  logic        rdV0, rdV1, rdV2;

  int checks   = 0;
  int failures = 0;
  bit dataKnown = 1'b0;

  int depthOf  [3] = '{16, 12, 16};
  bit fwdOf    [3] = '{1'b1, 1'b0, 1'b1};
  bit rdModeOf [3] = '{1'b0, 1'b0, 1'b1};

  // Behavioural model state, one set per instance
  logic [31:0] mMem [3][16];
  bit          mVal [3][16];
  bit          pV   [3];
  logic [3:0]  pA   [3];
  logic [31:0] pD   [3];
  logic [3:0]  pS   [3];
  logic [31:0] rq   [3];
  bit          rv   [3];

  coreaxitoahbl_ram_strb_sync #(
    .AXI_DWIDTH(32), .AXI_STRBWIDTH(4), .DEPTH(16), .ADDR_WIDTH(4), .RD_MODE(0), .FWD_EN(1)
  ) dut0 (
    .CLK(CLK), .RESET(RESET), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrStrb(wrStrb), .clrValid(clrValid), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdD0), .rdValid(rdV0)
  );

  coreaxitoahbl_ram_strb_sync #(
    .AXI_DWIDTH(32), .AXI_STRBWIDTH(4), .DEPTH(12), .ADDR_WIDTH(4), .RD_MODE(0), .FWD_EN(0)
  ) dut1 (
    .CLK(CLK), .RESET(RESET), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrStrb(wrStrb), .clrValid(clrValid), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdD1), .rdValid(rdV1)
  );

  coreaxitoahbl_ram_strb_sync #(
    .AXI_DWIDTH(32), .AXI_STRBWIDTH(4), .DEPTH(16), .ADDR_WIDTH(4), .RD_MODE(1), .FWD_EN(1)
  ) dut2 (
    .CLK(CLK), .RESET(RESET), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrStrb(wrStrb), .clrValid(clrValid), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdD2), .rdValid(rdV2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // What a read of address a on instance k returns right now
  task automatic modelRead(input int k, input logic [3:0] a,
                           output logic [31:0] d, output bit v);
    d = '0;
    v = 1'b0;
    if (int'(a) < depthOf[k]) begin
      d = mMem[k][a];
      v = mVal[k][a];
      if (fwdOf[k] && pV[k] && pA[k] == a) begin
        for (int b = 0; b < 4; b++)
          if (pS[k][b]) d[8*b +: 8] = pD[k][8*b +: 8];
        v = 1'b1;
      end
    end
  endtask

  // Advance every model by one rising edge using the current inputs
  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      if (RESET) begin
        pV[k] = 1'b0;
        for (int a = 0; a < 16; a++) mVal[k][a] = 1'b0;
        rq[k] = '0;
        rv[k] = 1'b0;
      end else begin
        if (rdModeOf[k] && rdEn) modelRead(k, rdAddr, rq[k], rv[k]);
        if (pV[k]) begin
          for (int b = 0; b < 4; b++)
            if (pS[k][b]) mMem[k][pA[k]][8*b +: 8] = pD[k][8*b +: 8];
          mVal[k][pA[k]] = 1'b1;
        end
        if (clrValid)
          for (int a = 0; a < 16; a++) mVal[k][a] = 1'b0;
        pV[k] = wrEn && (int'(wrAddr) < depthOf[k]);
        pA[k] = wrAddr;
        pD[k] = wrData;
        pS[k] = wrStrb;
      end
    end
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the next falling edge
  task automatic runCycle();
    logic [31:0] expD;
    bit          expV;
    logic [31:0] gotD [3];
    logic        gotV [3];
    #1;
    gotD[0] = rdD0; gotD[1] = rdD1; gotD[2] = rdD2;
    gotV[0] = rdV0; gotV[1] = rdV1; gotV[2] = rdV2;
    for (int k = 0; k < 3; k++) begin
      if (rdModeOf[k]) begin
        expD = rq[k];
        expV = rv[k];
      end else begin
        modelRead(k, rdAddr, expD, expV);
      end
      checkVal($sformatf("dut%0d_valid", k), {31'b0, gotV[k]}, {31'b0, expV});
      if (dataKnown || rdModeOf[k])
        checkVal($sformatf("dut%0d_data", k), gotD[k], expD);
    end
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
  endtask

  task automatic setIdle();
    RESET    = 1'b0;
    wrEn     = 1'b0;
    wrStrb   = '0;
    clrValid = 1'b0;
    rdEn     = 1'b0;
  endtask

  task automatic setWr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    setIdle();
    wrEn   = 1'b1;
    wrAddr = a;
    wrData = d;
    wrStrb = s;
  endtask

  logic [31:0] oldWord;

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) begin
        mMem[k][a] = '0;
        mVal[k][a] = 1'b0;
      end
      pV[k] = 1'b0; pA[k] = '0; pD[k] = '0; pS[k] = '0;
      rq[k] = '0;   rv[k] = 1'b0;
    end
    setIdle();
    RESET  = 1'b1;
    wrAddr = '0;
    wrData = '0;
    rdAddr = '0;
    @(negedge CLK);
    runCycle();
    runCycle();

    // Reset state
    setIdle();
    #1;
    checkVal("rst_valid0", {31'b0, rdV0}, 32'd0);
    checkVal("rst_valid1", {31'b0, rdV1}, 32'd0);
    checkVal("rst_valid2", {31'b0, rdV2}, 32'd0);
    checkVal("rst_data2",  rdD2, 32'd0);
    runCycle();

    // Preload every entry so later data comparisons are well defined
    for (int a = 0; a < 16; a++) begin
      setWr(4'(a), $urandom, 4'hF);
      rdAddr = 4'(a);
      runCycle();
    end
    setIdle();
    runCycle();
    clrValid = 1'b1;
    runCycle();
    setIdle();
    dataKnown = 1'b1;
    runCycle();

    // Strobed merge, back-to-back writes to the same address
    setWr(4'd3, 32'hAABBCCDD, 4'hF); rdAddr = 4'd3; runCycle();
    setWr(4'd3, 32'h11223344, 4'h5); runCycle();
    setIdle(); runCycle();
    setIdle();
    #1;
    checkVal("merge_data",  rdD0, 32'hAA22CC44);
    checkVal("merge_valid", {31'b0, rdV0}, 32'd1);
    runCycle();

    // Forwarding vs no forwarding after a fresh reset
    setIdle(); RESET = 1'b1; runCycle();
    setWr(4'd7, 32'h12345678, 4'hF); runCycle();
    setIdle(); rdAddr = 4'd7;
    #1;
    checkVal("fwd_data",     rdD0, 32'h12345678);
    checkVal("fwd_valid",    {31'b0, rdV0}, 32'd1);
    checkVal("nofwd_valid",  {31'b0, rdV1}, 32'd0);
    checkVal("nofwd_data",   rdD1, mMem[1][7]);
    runCycle();

    // Registered read holds while rdEn is low
    setWr(4'd2, 32'hCAFEF00D, 4'hF); runCycle();
    setIdle(); runCycle();
    setIdle(); rdEn = 1'b1; rdAddr = 4'd2; runCycle();
    setIdle(); rdAddr = 4'd5;
    #1;
    checkVal("rdreg_data",  rdD2, 32'hCAFEF00D);
    checkVal("rdreg_valid", {31'b0, rdV2}, 32'd1);
    runCycle();
    setIdle(); rdAddr = 4'd9;
    #1;
    checkVal("rdreg_hold", rdD2, 32'hCAFEF00D);
    runCycle();

    // clrValid coinciding with a commit
    setWr(4'd5, 32'h5A5A1234, 4'hF); runCycle();
    setIdle(); clrValid = 1'b1; runCycle();
    setIdle(); rdAddr = 4'd5;
    #1;
    checkVal("clr_valid", {31'b0, rdV0}, 32'd0);
    checkVal("clr_data",  rdD0, 32'h5A5A1234);
    runCycle();

    // Reset while a write is pending cancels the commit
    oldWord = mMem[0][9];
    setWr(4'd9, (oldWord == 32'h55) ? 32'h56 : 32'h55, 4'hF); runCycle();
    setIdle(); RESET = 1'b1; runCycle();
    setIdle(); rdAddr = 4'd9;
    #1;
    checkVal("rstwr_data", rdD0, oldWord);
    runCycle();
    for (int a = 0; a < 16; a++) begin
      setIdle(); rdAddr = 4'(a);
      #1;
      checkVal($sformatf("rstwr_valid%0d", a), {31'b0, rdV0}, 32'd0);
      runCycle();
    end

    // Out-of-range address on the DEPTH=12 instance
    setWr(4'd14, 32'hDEADBEEF, 4'hF); rdAddr = 4'd14; runCycle();
    setIdle(); runCycle();
    setIdle(); rdAddr = 4'd14;
    #1;
    checkVal("oor_data",  rdD1, 32'd0);
    checkVal("oor_valid", {31'b0, rdV1}, 32'd0);
    runCycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      setIdle();
      RESET    = ($urandom_range(0, 63) == 0);
      wrEn     = ($urandom_range(0, 2) != 0);
      wrAddr   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) wrAddr = rdAddr;
      wrData   = $urandom;
      wrStrb   = 4'($urandom_range(0, 15));
      clrValid = ($urandom_range(0, 19) == 0);
      rdEn     = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 2) != 0) rdAddr = 4'($urandom_range(0, 15));
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coreaxitoahbl_ram_strb_sync.md
COREAXITOAHBL_RAM_STRB_SYNC -- requirements
Module: coreaxitoahbl_ram_strb_sync

Interface
REQ-001 SHALL have parameter AXI_DWIDTH, default 64, data width in bits (multiple of 8; 32/64/128 supported).
REQ-002 SHALL have parameter AXI_STRBWIDTH, default 8, byte-strobe width (AXI_DWIDTH/8).
REQ-003 SHALL have parameter DEPTH, default 16, number of entries (2..256, not required power of two).
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, address width (>= ceil(log2(DEPTH))).
REQ-005 SHALL have parameter RD_MODE, default 0, 0 = asynchronous read, 1 = registered read.
REQ-006 SHALL have parameter FWD_EN, default 1, 1 = forward pending write data to the read port.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 CLK  input  1  sole clock; all state updates on rising edge.
REQ-009 RESET  input  1  synchronous active-high reset.
REQ-010 wrEn  input  1  write request.
REQ-011 wrAddr  input  ADDR_WIDTH  write address.
REQ-012 wrData  input  AXI_DWIDTH  write data.
REQ-013 wrStrb  input  AXI_STRBWIDTH  byte enables; bit i covers wrData[8i+7:8i].
REQ-014 clrValid  input  1  single-cycle pulse: invalidate all entries.
REQ-015 rdEn  input  1  read strobe; used only when RD_MODE=1.
REQ-016 rdAddr  input  ADDR_WIDTH  read address.
REQ-017 rdData  output  AXI_DWIDTH  read data.
REQ-018 rdValid  output  1  addressed entry holds committed or forwarded data.

Function
REQ-019 Write path SHALL be two-stage: edge N registers wrEn/wrAddr/wrData/wrStrb (pending stage); edge N+1 commits pending data to memory.
REQ-020 Commit SHALL update only bytes whose pending strobe bit is 1; other bytes retain prior contents.
REQ-021 Pending write with wrStrb all-zero SHALL leave memory unchanged but SHALL set the entry valid bit.
REQ-022 Writes with wrAddr >= DEPTH SHALL be dropped: no memory change, no valid change.
REQ-023 SHALL keep one valid bit per entry, set on commit, cleared by RESET or clrValid.
REQ-024 clrValid and a commit in the same cycle: clrValid wins; all valid bits 0 after the edge, memory data still written.
REQ-025 RD_MODE=0: rdData/rdValid SHALL be combinational functions of rdAddr, memory, valid bits and pending stage.
REQ-026 RD_MODE=1: rdData/rdValid SHALL update on the edge where rdEn=1 (1-cycle latency) and hold when rdEn=0.
REQ-027 FWD_EN=1 and pending valid with pending address == rdAddr: bytes with pending strobe 1 SHALL come from pending data, other bytes from memory; rdValid SHALL be 1.
REQ-028 FWD_EN=0: read SHALL return memory contents only; pending data becomes visible after commit.
REQ-029 New write to same address on back-to-back cycles SHALL commit both in order; last write wins per byte.
REQ-030 rdAddr >= DEPTH SHALL return rdData = 0 and rdValid = 0.
REQ-031 Read and write to different addresses in the same cycle SHALL not interact.

Reset
REQ-032 RESET=1 at an edge SHALL clear the pending stage (cancelling any uncommitted write), all valid bits, and, in RD_MODE=1, rdData to 0 and rdValid to 0.
REQ-033 Memory array contents SHALL not be reset; reads after reset return stale data with rdValid=0.
REQ-034 RESET SHALL take priority over wrEn, rdEn and clrValid in the same cycle.
REQ-035 RESET asserted in the cycle a write is pending SHALL prevent that commit.

Verification (AXI_DWIDTH=32, DEPTH=16 unless stated)
REQ-036 Strobed merge: write 0xAABBCCDD strb 0xF addr 3, then 0x11223344 strb 0x5 addr 3; after commit read addr 3 -> 0xAA22CC44, rdValid=1.
REQ-037 Forwarding, RD_MODE=0, FWD_EN=1: write 0x12345678 strb 0xF addr 7, rdAddr=7 in pending cycle -> rdData=0x12345678, rdValid=1; with FWD_EN=0 same cycle -> old data, rdValid=0 (fresh reset).
REQ-038 Registered read, RD_MODE=1: rdEn pulse with rdAddr=2 holding 0xCAFEF00D -> rdData=0xCAFEF00D one edge later, unchanged while rdEn=0 and rdAddr changes.
REQ-039 clrValid collision: commit to addr 5 coincident with clrValid -> rdValid=0 at addr 5, rdData at addr 5 = written value.
REQ-040 Reset mid-write: wrEn addr 9 data 0x55 at edge N, RESET=1 at edge N+1 -> addr 9 memory unchanged, all rdValid=0.
REQ-041 DEPTH=12: write addr 14 -> no memory change; rdAddr=14 -> rdData=0, rdValid=0.
